// File: rtl/pixel_grid_streamer_pkg.sv
// Shared constants and FSM encoding for the 28x28 drawing grid.
// Used by the drawing stage, this streamer and the NN loader.
package pixel_grid_streamer_pkg;

  localparam int GRID_SIZE  = 28;
  localparam int NUM_PIXELS = GRID_SIZE * GRID_SIZE;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;

  localparam logic [DATA_W-1:0] PIX_ON  = 8'd255;
  localparam logic [DATA_W-1:0] PIX_OFF = 8'd0;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pixel_grid_streamer.sv
// Streams the 28x28 1-bit bitmap as 8-bit pixels over valid/ready and
// counts the set cells of the frame.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_FETCH | bitmap address for idx presented
//   S_LATCH | read data captured into the output beat
//   S_SEND  | beat held until accepted
//   S_DONE  | one-cycle done pulse
module pixel_grid_streamer
  import pixel_grid_streamer_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] on_count
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_on_count;
  logic [ADDR_W-1:0] r_out_index;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_out_valid;

  logic              w_handshake;
  logic [ADDR_W-1:0] w_idx_inc;

  assign w_handshake = r_out_valid && out_ready;
  assign w_idx_inc   = r_idx + ADDR_W'(1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_LATCH;
      S_LATCH: w_next = S_SEND;
      S_SEND:  if (w_handshake) w_next = r_out_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The address is loaded on entry to FETCH so it is already stable for the
  // whole FETCH cycle and otherwise holds its last value.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_idx       <= '0;
      r_mem_addr  <= '0;
      r_on_count  <= '0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_mem_addr <= '0;
            r_on_count <= '0;
          end
        end
        S_LATCH: begin
          r_out_data  <= mem_rd_data ? PIX_ON : PIX_OFF;
          r_out_index <= r_idx;
          r_out_last  <= (r_idx == LAST_IDX);
          r_out_valid <= 1'b1;
          r_on_count  <= r_on_count + ADDR_W'(mem_rd_data);
        end
        S_SEND: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (!r_out_last) begin
              r_idx      <= w_idx_inc;
              r_mem_addr <= w_idx_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign on_count  = r_on_count;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_pixel_grid_streamer.sv
// Directed bench for pixel_grid_streamer: bitmap model with a synchronous
// read port and a consumer that scores every accepted beat.
module tb_pixel_grid_streamer;
  import pixel_grid_streamer_pkg::*;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_data = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] on_count;

  pixel_grid_streamer dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .on_count    (on_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic bitmap [0:NUM_PIXELS-1];

  always @(posedge CLOCK_50)
    mem_rd_data <= (int'(mem_addr) < NUM_PIXELS) ? bitmap[mem_addr] : 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int res_beats, res_on_beats, res_data_err, res_idx_err, res_last_err;
  int res_hold_err, res_addr_err, res_done_cnt, res_idle_err;
  int res_first_valid, res_done_slot, res_start_slot, res_timeout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input bit rnd_ready, input bit poke, input int rst_beat);
    int s0;
    bit pv, pr, pacc, poked;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W-1:0] pi;
    logic pl;
    int nd;
    res_beats = 0; res_on_beats = 0; res_data_err = 0; res_idx_err = 0;
    res_last_err = 0; res_hold_err = 0; res_addr_err = 0; res_done_cnt = 0;
    res_idle_err = 0; res_first_valid = -1; res_done_slot = -1; res_timeout = 0;
    pv = 0; pr = 0; pacc = 1; poked = 0; pd = '0; pi = '0; pl = 0;
    s0 = cyc;
    res_start_slot = cyc;
    start = 1'b1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    while (cyc - s0 < 12000) begin
      start = 1'b0;
      if (pv && !pr && ({out_data, out_index, out_last, out_valid} !== {pd, pi, pl, 1'b1}))
        res_hold_err++;
      if (pacc && res_beats < NUM_PIXELS && mem_addr !== ADDR_W'(res_beats))
        res_addr_err++;
      if (out_valid && res_first_valid < 0) res_first_valid = cyc;
      if (done) begin
        res_done_cnt++;
        res_done_slot = cyc;
        if (poke) start = 1'b1;
      end
      if (res_done_cnt > 0 && cyc > res_done_slot && busy) res_idle_err++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && !poked && res_beats == 100 && out_valid) begin
        start = 1'b1;
        poked = 1;
      end
      if (rst_beat >= 0 && res_beats == rst_beat && out_valid) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.on_count", 32'(on_count), 0);
        chk("rst.out_index", 32'(out_index), 0);
        chk("rst.mem_addr", 32'(mem_addr), 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
          if (done) nd++;
          step();
        end
        chk("rst.no_done", 32'(nd), 0);
        return;
      end
      pacc = out_valid && out_ready;
      if (pacc) begin
        if (out_data !== (bitmap[res_beats] ? PIX_ON : PIX_OFF)) res_data_err++;
        if (out_index !== ADDR_W'(res_beats)) res_idx_err++;
        if (out_last !== (res_beats == NUM_PIXELS - 1)) res_last_err++;
        if (out_data === PIX_ON) res_on_beats++;
        res_beats++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
      if (res_done_cnt > 0 && cyc >= res_done_slot + 3) break;
      step();
    end
    if (cyc - s0 >= 12000) res_timeout = 1;
    start = 1'b0;
  endtask

  task automatic score(input string t, input int exp_on);
    chk({t, ".timeout"}, 32'(res_timeout), 0);
    chk({t, ".beats"}, 32'(res_beats), 32'(NUM_PIXELS));
    chk({t, ".data_err"}, 32'(res_data_err), 0);
    chk({t, ".idx_err"}, 32'(res_idx_err), 0);
    chk({t, ".last_err"}, 32'(res_last_err), 0);
    chk({t, ".hold_err"}, 32'(res_hold_err), 0);
    chk({t, ".addr_err"}, 32'(res_addr_err), 0);
    chk({t, ".done_cnt"}, 32'(res_done_cnt), 1);
    chk({t, ".idle_after"}, 32'(res_idle_err), 0);
    chk({t, ".on_beats"}, 32'(res_on_beats), 32'(exp_on));
    chk({t, ".on_count"}, 32'(on_count), 32'(exp_on));
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < NUM_PIXELS; i++) begin
      case (kind)
        0: bitmap[i] = 1'b0;
        1: bitmap[i] = (i == 0) || (i == 405) || (i == 783);
        2: bitmap[i] = (((i / GRID_SIZE) + (i % GRID_SIZE)) % 2) == 0;
        default: bitmap[i] = 1'b1;
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    fill(0);
    repeat (3) step();
    chk("reset.busy", 32'(busy), 0);
    chk("reset.valid", 32'(out_valid), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.mem_addr", 32'(mem_addr), 0);
    chk("reset.on_count", 32'(on_count), 0);
    chk("reset.out_data", 32'(out_data), 0);
    chk("reset.out_index", 32'(out_index), 0);
    chk("reset.out_last", 32'(out_last), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    chk("idle.ready_no_effect", 32'(busy), 0);

    fill(0);
    run_frame(1'b0, 1'b0, -1);
    score("clear", 0);
    chk("clear.first_valid_lat", 32'(res_first_valid - res_start_slot), 3);
    chk("clear.done_lat", 32'(res_done_slot - res_start_slot), 2353);
    repeat (2) step();

    fill(1);
    run_frame(1'b0, 1'b0, -1);
    score("three", 3);
    repeat (2) step();

    fill(2);
    run_frame(1'b1, 1'b0, -1);
    score("checker_bp", 392);
    repeat (2) step();

    run_frame(1'b0, 1'b1, -1);
    score("restart_ignored", 392);
    repeat (2) step();

    run_frame(1'b0, 1'b0, 500);
    run_frame(1'b0, 1'b0, -1);
    score("after_reset", 392);
    repeat (2) step();

    fill(3);
    run_frame(1'b1, 1'b0, -1);
    score("all_set", 784);
    chk("all_set.on_count_hex", 32'(on_count), 32'h310);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
